// File: rtl/io_pmp_check_if.sv
// Request/response bus of the IO PMP checker: requests carry address, direction and id; responses add the allow verdict.
interface io_pmp_check_if #(
    parameter int PLEN     = 56,
    parameter int ID_WIDTH = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [PLEN-1:0]     req_addr;
    logic                req_write;
    logic [ID_WIDTH-1:0] req_id;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [PLEN-1:0]     rsp_addr;
    logic                rsp_write;
    logic [ID_WIDTH-1:0] rsp_id;
    logic                rsp_allow;

    modport master (
        output req_valid, req_addr, req_write, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_write, rsp_id, rsp_allow
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_write, rsp_id, rsp_allow
    );
endinterface

// File: rtl/io_pmp_check.sv
// IO PMP checker: matches each request against OFF/TOR/NA4/NAPOT entries, lowest index wins, no match denies.
// Latency: one cycle through a two-slot spill register; zero with IO_PMP_BYPASS_EN defined (pure wire).
// Backpressure: req_ready depends only on fill state (low when both slots full); bypass forwards rsp_ready.
module io_pmp_check #(
    parameter int PLEN       = 56,
    parameter int PMP_LEN    = 54,
    parameter int NR_ENTRIES = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_we_i,
    input  logic [3:0]         cfg_idx_i,
    input  logic [PMP_LEN-1:0] cfg_addr_i,
    input  logic [7:0]         cfg_cfg_i,
    io_pmp_check_if.slave      bus
);
    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    logic [PMP_LEN-1:0] pmp_addr [NR_ENTRIES];
    logic [7:0]         pmp_cfg  [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] addr_lock;
    logic [NR_ENTRIES-1:0] match;
    logic [PMP_LEN-1:0]    word_addr;
    logic                  allow_c;

    assign word_addr = bus.req_addr[PLEN-1:2];

    // A locked TOR entry also freezes the address of the entry below it (its base).
    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_lock
        if (i < NR_ENTRIES - 1) begin : g_next
            assign addr_lock[i] = pmp_cfg[i+1][7] && (pmp_cfg[i+1][4:3] == A_TOR);
        end else begin : g_last
            assign addr_lock[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                pmp_addr[i] <= '0;
                pmp_cfg[i]  <= '0;
            end
        end else if (cfg_we_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (cfg_idx_i == 4'(i) && !pmp_cfg[i][7]) begin
                    pmp_cfg[i] <= cfg_cfg_i & 8'h9F;
                    if (!addr_lock[i]) begin
                        pmp_addr[i] <= cfg_addr_i;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_match
        logic [PMP_LEN-1:0] prev;
        logic [PMP_LEN-1:0] napot_mask;

        if (i == 0) begin : g_base0
            assign prev = '0;
        end else begin : g_basen
            assign prev = pmp_addr[i-1];
        end

        // Clears the trailing ones plus the first zero; all-ones pmpaddr yields an empty mask.
        assign napot_mask = ~(pmp_addr[i] ^ (pmp_addr[i] + PMP_LEN'(1)));

        always_comb begin
            match[i] = 1'b0;
            case (pmp_cfg[i][4:3])
                A_OFF:   match[i] = 1'b0;
                A_TOR:   match[i] = (word_addr >= prev) && (word_addr < pmp_addr[i]);
                A_NA4:   match[i] = (word_addr == pmp_addr[i]);
                A_NAPOT: match[i] = ((word_addr ^ pmp_addr[i]) & napot_mask) == '0;
                default: match[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        allow_c = 1'b0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                allow_c = bus.req_write ? pmp_cfg[i][1] : pmp_cfg[i][0];
            end
        end
    end

`ifdef IO_PMP_BYPASS_EN
    assign bus.rsp_valid = bus.req_valid;
    assign bus.req_ready = bus.rsp_ready;
    assign bus.rsp_addr  = bus.req_addr;
    assign bus.rsp_write = bus.req_write;
    assign bus.rsp_id    = bus.req_id;
    assign bus.rsp_allow = allow_c;
`else
    typedef struct packed {
        logic [PLEN-1:0]     addr;
        logic                write;
        logic [ID_WIDTH-1:0] id;
        logic                allow;
    } slot_t;

    slot_t in_slot, a_slot, b_slot;
    logic  a_full, b_full, push, pop;

    assign in_slot = '{addr: bus.req_addr, write: bus.req_write, id: bus.req_id, allow: allow_c};
    assign bus.req_ready = !b_full;
    assign bus.rsp_valid = a_full;
    assign push = bus.req_valid && !b_full;
    assign pop  = a_full && bus.rsp_ready;

    // Slot a is the head presented on rsp; slot b only fills when a is stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
        end else if (b_full) begin
            if (pop) begin
                b_full <= 1'b0;
            end
        end else if (a_full && !pop) begin
            b_full <= push;
        end else begin
            a_full <= push;
        end
    end

    always_ff @(posedge clk_i) begin
        if (b_full) begin
            if (pop) begin
                a_slot <= b_slot;
            end
        end else if (a_full && !pop) begin
            if (push) begin
                b_slot <= in_slot;
            end
        end else if (push) begin
            a_slot <= in_slot;
        end
    end

    assign bus.rsp_addr  = a_slot.addr;
    assign bus.rsp_write = a_slot.write;
    assign bus.rsp_id    = a_slot.id;
    assign bus.rsp_allow = a_slot.allow;
`endif
endmodule

// File: tb/tb_io_pmp_check.sv
// Bench for io_pmp_check: directed scenarios plus randomized traffic scored against a rule-level PMP model.
module tb_io_pmp_check;
    localparam int PLEN = 56;
    localparam int PMP_LEN = 54;
    localparam int NR = 8;
    localparam int IDW = 8;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic cfg_we_i = 1'b0;
    logic [3:0] cfg_idx_i = '0;
    logic [PMP_LEN-1:0] cfg_addr_i = '0;
    logic [7:0] cfg_cfg_i = '0;

    io_pmp_check_if #(.PLEN(PLEN), .ID_WIDTH(IDW)) bus ();

    io_pmp_check #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .ID_WIDTH(IDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
        .cfg_addr_i(cfg_addr_i), .cfg_cfg_i(cfg_cfg_i), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: entry table and outstanding responses in acceptance order.
    logic [PMP_LEN-1:0] m_addr [NR];
    logic [7:0]         m_cfg  [NR];
    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic            wr;
        logic [IDW-1:0]  id;
        logic            allow;
    } exp_t;
    exp_t sb[$];
    exp_t held;
    bit   held_vld = 1'b0;

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_addr[i] = '0;
            m_cfg[i] = '0;
        end
    endfunction

    function automatic void model_write(input int idx, input logic [PMP_LEN-1:0] a, input logic [7:0] c);
        if (idx >= NR) return;
        if (m_cfg[idx][7]) return;
        if (!(idx + 1 < NR && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'd1)) m_addr[idx] = a;
        m_cfg[idx] = c & 8'h9F;
    endfunction

    function automatic logic model_allow(input logic [PLEN-1:0] a, input logic wr);
        logic [PMP_LEN-1:0] w, lo;
        bit hit;
        int k;
        w = a[PLEN-1:2];
        for (int i = 0; i < NR; i++) begin
            hit = 1'b0;
            case (m_cfg[i][4:3])
                2'd1: begin
                    lo = (i == 0) ? '0 : m_addr[i-1];
                    hit = (w >= lo) && (w < m_addr[i]);
                end
                2'd2: hit = (w == m_addr[i]);
                2'd3: begin
                    k = 0;
                    while (k < PMP_LEN && m_addr[i][k]) k++;
                    hit = (k == PMP_LEN) ? 1'b1 : ((w >> (k + 1)) == (m_addr[i] >> (k + 1)));
                end
                default: hit = 1'b0;
            endcase
            if (hit) return wr ? m_cfg[i][1] : m_cfg[i][0];
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        bus.req_valid = 1'b0;
        cfg_we_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_clear();
        sb.delete();
        held_vld = 1'b0;
        check_eq("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("reset_req_ready", bus.req_ready, 1'b1);
    endtask

    task automatic cfg_write(input int idx, input logic [PMP_LEN-1:0] a, input logic [7:0] c);
        @(negedge clk_i);
        cfg_we_i = 1'b1;
        cfg_idx_i = 4'(idx);
        cfg_addr_i = a;
        cfg_cfg_i = c;
        model_write(idx, a, c);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    bit pend_cfg = 1'b0;
    logic [7:0] pend_cfg_val = '0;

    // One request with rsp_ready high; optional config write to entry 0 in the same cycle.
    task automatic req_check(input string tag, input logic [PLEN-1:0] a, input logic wr,
                             input logic [IDW-1:0] id, input logic exp_allow);
        @(negedge clk_i);
        check_eq({tag, "_req_ready"}, bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        bus.req_write = wr;
        bus.req_id = id;
        bus.rsp_ready = 1'b1;
        if (pend_cfg) begin
            cfg_we_i = 1'b1;
            cfg_idx_i = 4'd0;
            cfg_addr_i = 54'h400;
            cfg_cfg_i = pend_cfg_val;
            pend_cfg = 1'b0;
        end
        @(negedge clk_i);
        bus.req_valid = 1'b0;
        cfg_we_i = 1'b0;
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        check_eq({tag, "_allow"}, bus.rsp_allow, exp_allow);
        check_eq({tag, "_id"}, bus.rsp_id, id);
        check_eq({tag, "_addr"}, bus.rsp_addr, a);
    endtask

    task automatic step(input bit gen_traffic);
        exp_t got, e;
        bit rr;
        logic [63:0] r;
        logic [PMP_LEN-1:0] pa;
        int k;
        @(negedge clk_i);
        check_eq("ready_vs_fill", bus.req_ready, sb.size() < 2);
        check_eq("valid_vs_fill", bus.rsp_valid, sb.size() != 0);
        got = '{addr: bus.rsp_addr, wr: bus.rsp_write, id: bus.rsp_id, allow: bus.rsp_allow};
        if (held_vld) begin
            check_eq("stall_addr", got.addr, held.addr);
            check_eq("stall_ctl", {got.wr, got.id, got.allow}, {held.wr, held.id, held.allow});
        end
        rr = gen_traffic ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.rsp_ready = rr;
        if (bus.rsp_valid && rr && sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("rsp_addr", got.addr, e.addr);
            check_eq("rsp_ctl", {got.wr, got.id, got.allow}, {e.wr, e.id, e.allow});
        end
        held_vld = bus.rsp_valid && !rr;
        held = got;

        bus.req_valid = gen_traffic && ($urandom_range(0, 2) != 0);
        r = {$urandom, $urandom};
        bus.req_addr = ($urandom_range(0, 7) == 0) ? r[PLEN-1:0] : PLEN'($urandom_range(0, 'h7FFF));
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_id = IDW'($urandom);
        if (bus.req_valid && bus.req_ready)
            sb.push_back('{addr: bus.req_addr, wr: bus.req_write, id: bus.req_id,
                           allow: model_allow(bus.req_addr, bus.req_write)});

        cfg_we_i = gen_traffic && ($urandom_range(0, 3) == 0);
        cfg_idx_i = 4'($urandom_range(0, 15));
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: pa = PMP_LEN'($urandom_range(0, 'h1FFF));
            1: begin
                k = $urandom_range(0, 10);
                pa = (PMP_LEN'($urandom_range(0, 7)) << (k + 1)) | ((PMP_LEN'(1) << k) - PMP_LEN'(1));
            end
            2: pa = {PMP_LEN{1'b1}};
            default: pa = r[PMP_LEN-1:0];
        endcase
        cfg_addr_i = pa;
        cfg_cfg_i = 8'($urandom) & 8'h7F;
        if ($urandom_range(0, 63) == 0) cfg_cfg_i[7] = 1'b1;
        if (cfg_we_i) model_write(int'(cfg_idx_i), cfg_addr_i, cfg_cfg_i);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_write = 1'b0;
        bus.req_id = '0;
        bus.rsp_ready = 1'b1;
        model_clear();

        do_reset();
        req_check("no_match", 56'h1000, 1'b0, 8'h01, 1'b0);

        cfg_write(0, 54'h3FF, 8'h1B);
        req_check("napot_rd0", 56'h0, 1'b0, 8'h02, 1'b1);
        req_check("napot_wr0", 56'h0, 1'b1, 8'h03, 1'b1);
        req_check("napot_rd_top", 56'h1FFF, 1'b0, 8'h04, 1'b1);
        req_check("napot_wr_top", 56'h1FFF, 1'b1, 8'h05, 1'b1);
        req_check("napot_out", 56'h2000, 1'b0, 8'h06, 1'b0);

        cfg_write(0, 54'h400, 8'h09);
        req_check("tor_rd_in", 56'hFFC, 1'b0, 8'h07, 1'b1);
        req_check("tor_wr_in", 56'hFFC, 1'b1, 8'h08, 1'b0);
        req_check("tor_rd_top", 56'h1000, 1'b0, 8'h09, 1'b0);

        cfg_write(0, 54'h400, 8'h11);
        cfg_write(1, {PMP_LEN{1'b1}}, 8'h1B);
        req_check("prio_wr_na4", 56'h1000, 1'b1, 8'h0A, 1'b0);
        req_check("prio_wr_all", 56'h1004, 1'b1, 8'h0B, 1'b1);
        req_check("prio_rd_na4", 56'h1000, 1'b0, 8'h0C, 1'b1);

        pend_cfg = 1'b1;
        pend_cfg_val = 8'h13;
        req_check("same_cycle_old", 56'h1000, 1'b1, 8'h0D, 1'b0);
        req_check("same_cycle_new", 56'h1000, 1'b1, 8'h0E, 1'b1);

        do_reset();
        cfg_write(1, 54'h800, 8'h00);
        cfg_write(2, 54'hC00, 8'h89);
        req_check("lock_rd_in", 56'h2000, 1'b0, 8'h10, 1'b1);
        req_check("lock_wr_in", 56'h2000, 1'b1, 8'h11, 1'b0);
        cfg_write(2, 54'h0, 8'h00);
        cfg_write(1, 54'h0, 8'h00);
        req_check("lock_kept", 56'h2FFC, 1'b0, 8'h12, 1'b1);
        req_check("lock_base_kept", 56'h1000, 1'b0, 8'h13, 1'b0);
        req_check("lock_top", 56'h3000, 1'b0, 8'h14, 1'b0);
        do_reset();
        req_check("lock_cleared", 56'h2000, 1'b0, 8'h15, 1'b0);

        // Reset with two responses buffered drops them.
        @(negedge clk_i);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_id = 8'h20;
        @(negedge clk_i);
        bus.req_id = 8'h21;
        @(negedge clk_i);
        bus.req_valid = 1'b0;
        check_eq("midrst_full", bus.req_ready, 1'b0);
        do_reset();
        bus.rsp_ready = 1'b1;
        @(negedge clk_i);
        check_eq("midrst_empty", bus.rsp_valid, 1'b0);

        // Three back-to-back requests against a stalled consumer.
        @(negedge clk_i);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = 56'h100;
        bus.req_id = 8'd1;
        @(negedge clk_i);
        check_eq("b2b_rdy1", bus.req_ready, 1'b1);
        check_eq("b2b_head1", bus.rsp_id, 8'd1);
        bus.req_addr = 56'h200;
        bus.req_id = 8'd2;
        @(negedge clk_i);
        check_eq("b2b_full", bus.req_ready, 1'b0);
        bus.req_addr = 56'h300;
        bus.req_id = 8'd3;
        @(negedge clk_i);
        check_eq("b2b_still_full", bus.req_ready, 1'b0);
        check_eq("b2b_stable_id", bus.rsp_id, 8'd1);
        check_eq("b2b_stable_addr", bus.rsp_addr, 56'h100);
        bus.rsp_ready = 1'b1;
        @(negedge clk_i);
        check_eq("b2b_out2", bus.rsp_id, 8'd2);
        check_eq("b2b_rdy_again", bus.req_ready, 1'b1);
        @(negedge clk_i);
        bus.req_valid = 1'b0;
        check_eq("b2b_out3", bus.rsp_id, 8'd3);
        check_eq("b2b_out3_addr", bus.rsp_addr, 56'h300);
        @(negedge clk_i);
        check_eq("b2b_drained", bus.rsp_valid, 1'b0);

        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 699) do_reset();
            step(1'b1);
        end
        for (int i = 0; i < 6; i++) step(1'b0);
        @(negedge clk_i);
        check_eq("final_drain", bus.rsp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
